// File: rtl/rhd_frame_pkg.sv
// ============================================================================
// Module : rhd_frame_pkg
// Brief  : Shared constants, read-FSM encoding and word-wide CRC-16/CCITT step
//          for the RHD frame packer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rhd_frame_pkg;

   localparam logic [15:0] SYNC_WORD = 16'hA55A;
   localparam logic [15:0] CRC_POLY  = 16'h1021;
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;

   localparam int ST_W = 3;
   typedef logic [ST_W-1:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_SYNC    = 3'd1;
   localparam state_t ST_ID      = 3'd2;
   localparam state_t ST_PAYLOAD = 3'd3;
   localparam state_t ST_CRC     = 3'd4;

   // Sixteen MSB-first bit steps folded into one combinational word update.
   function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [15:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         if (c[15] ^ data[i]) begin
            c = {c[14:0], 1'b0} ^ CRC_POLY;
         end else begin
            c = {c[14:0], 1'b0};
         end
      end
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rhd_frame_packer_if.sv
// ============================================================================
// Module : rhd_frame_packer_if
// Brief  : Framed 16-bit valid/ready word stream toward the SPI master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rhd_frame_packer_if;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sof;
   logic        out_eof;

   modport master (
      output out_data,
      output out_valid,
      output out_sof,
      output out_eof,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_sof,
      input  out_eof,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/frame_crc16.sv
// ============================================================================
// Module : frame_crc16
// Brief  : CRC-16/CCITT accumulator, one 16-bit word per enabled cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_crc16
   import rhd_frame_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        enable,
   input  logic [15:0] data,
   output logic [15:0] crc
);

   logic [15:0] r_crc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= CRC_INIT;
      end else if (clear) begin
         r_crc <= CRC_INIT;
      end else if (enable) begin
         r_crc <= crc16_next(r_crc, data);
      end
   end

   assign crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/rhd_frame_packer.sv
// ============================================================================
// Module : rhd_frame_packer
// Brief  : Ping-pong frame buffer turning the RHD word stream into framed
//          SYNC/ID/payload[/CRC] beats; whole frames dropped on overflow.
//          Optional CRC beat enabled by defining FRAME_CRC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rhd_frame_packer
   import rhd_frame_pkg::*;
#(
   parameter int WORDS_PER_FRAME = 64,
   parameter int ID_W            = 16,
   parameter int OVF_W           = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        in_data,
   input  logic               in_valid,
   input  logic               resync,
   rhd_frame_packer_if.master out_if,
   output logic               overflow,
   output logic [OVF_W-1:0]   ovf_count
);

   localparam int                 c_idx_w    = $clog2(WORDS_PER_FRAME);
   localparam logic [c_idx_w-1:0] c_last_idx = '1;

   logic [15:0]        r_mem [2*WORDS_PER_FRAME];
   logic [15:0]        r_rd_data;

   logic [c_idx_w-1:0] r_widx;
   logic               r_wb;
   logic               r_drop;
   logic [1:0]         r_full;
   logic               r_overflow;
   logic [OVF_W-1:0]   r_ovf_count;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_idx_w-1:0] r_ridx;
   logic               r_rb;
   logic [ID_W-1:0]    r_frame_id;

   logic [c_idx_w-1:0] w_idx_eff;
   logic               w_drop_eff;
   logic               w_bank_busy;
   logic               w_dropping;
   logic               w_wr_en;
   logic               w_frame_done;
   logic               w_new_drop;
   logic               w_accept;
   logic               w_last_pay;
   logic               w_rd_done;
   logic               w_rd_en;
   logic [c_idx_w-1:0] w_raddr;
   logic [1:0]         w_full_set;
   logic [1:0]         w_full_clr;

   // ---------------- write side ----------------
   // resync in the same cycle as in_valid makes this word index 0 of a fresh frame.
   assign w_idx_eff    = resync ? '0 : r_widx;
   assign w_drop_eff   = resync ? 1'b0 : r_drop;
   assign w_bank_busy  = r_full[r_wb] && !(w_rd_done && (r_rb == r_wb));
   assign w_dropping   = (w_idx_eff == '0) ? w_bank_busy : w_drop_eff;
   assign w_wr_en      = in_valid && !w_dropping;
   assign w_frame_done = w_wr_en && (w_idx_eff == c_last_idx);
   assign w_new_drop   = in_valid && (w_idx_eff == '0) && w_bank_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_widx      <= '0;
         r_wb        <= 1'b0;
         r_drop      <= 1'b0;
         r_overflow  <= 1'b0;
         r_ovf_count <= '0;
      end else begin
         if (in_valid) begin
            if (w_idx_eff == c_last_idx) begin
               r_widx <= '0;
               r_drop <= 1'b0;
               if (!w_dropping) begin
                  r_wb <= ~r_wb;
               end
            end else begin
               r_widx <= w_idx_eff + 1'b1;
               r_drop <= w_dropping;
            end
            if (w_new_drop) begin
               r_overflow <= 1'b1;
               if (r_ovf_count != {OVF_W{1'b1}}) begin
                  r_ovf_count <= r_ovf_count + 1'b1;
               end
            end
         end else if (resync) begin
            r_widx <= '0;
            r_drop <= 1'b0;
         end
      end
   end

   // Writer set wins; the two can never target the same bank in one cycle anyway.
   assign w_full_set = w_frame_done ? (r_wb ? 2'b10 : 2'b01) : 2'b00;
   assign w_full_clr = w_rd_done    ? (r_rb ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 2'b00;
      end else begin
         r_full <= (r_full & ~w_full_clr) | w_full_set;
      end
   end

   // ---------------- buffer RAM ----------------
   // Read data only moves on an accepted beat, so payload stays stable under stall.
   assign w_rd_en = w_accept && ((r_state == ST_ID) || ((r_state == ST_PAYLOAD) && !w_last_pay));
   assign w_raddr = (r_state == ST_ID) ? '0 : (r_ridx + 1'b1);

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[{r_wb, w_idx_eff}] <= in_data;
      end
      if (w_rd_en) begin
         r_rd_data <= r_mem[{r_rb, w_raddr}];
      end
   end

   // ---------------- read side ----------------
   assign w_accept   = (r_state != ST_IDLE) && out_if.out_ready;
   assign w_last_pay = (r_state == ST_PAYLOAD) && (r_ridx == c_last_idx);
   assign w_rd_done  = w_accept && w_last_pay;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ridx     <= '0;
         r_rb       <= 1'b0;
         r_frame_id <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept && (r_state == ST_ID)) begin
            r_ridx <= '0;
         end else if (w_accept && (r_state == ST_PAYLOAD) && !w_last_pay) begin
            r_ridx <= r_ridx + 1'b1;
         end
         if (w_rd_done) begin
            r_rb       <= ~r_rb;
            r_frame_id <= r_frame_id + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (r_full[r_rb]) w_state_nxt = ST_SYNC;
         ST_SYNC:    if (w_accept)     w_state_nxt = ST_ID;
         ST_ID:      if (w_accept)     w_state_nxt = ST_PAYLOAD;
         ST_PAYLOAD: begin
            if (w_rd_done) begin
`ifdef FRAME_CRC_EN
               w_state_nxt = ST_CRC;
`else
               w_state_nxt = ST_IDLE;
`endif
            end
         end
         ST_CRC:     if (w_accept)     w_state_nxt = ST_IDLE;
         default:                      w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef FRAME_CRC_EN
   logic [15:0] w_crc;
   logic [15:0] w_crc_data;

   assign w_crc_data = (r_state == ST_ID) ? 16'(r_frame_id) : r_rd_data;

   frame_crc16 u_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (w_accept && (r_state == ST_SYNC)),
      .enable (w_accept && ((r_state == ST_ID) || (r_state == ST_PAYLOAD))),
      .data   (w_crc_data),
      .crc    (w_crc)
   );
`endif

   always_comb begin
      out_if.out_data  = '0;
      out_if.out_valid = 1'b0;
      out_if.out_sof   = 1'b0;
      out_if.out_eof   = 1'b0;
      case (r_state)
         ST_SYNC: begin
            out_if.out_valid = 1'b1;
            out_if.out_sof   = 1'b1;
            out_if.out_data  = SYNC_WORD;
         end
         ST_ID: begin
            out_if.out_valid = 1'b1;
            out_if.out_data  = 16'(r_frame_id);
         end
         ST_PAYLOAD: begin
            out_if.out_valid = 1'b1;
            out_if.out_data  = r_rd_data;
`ifndef FRAME_CRC_EN
            out_if.out_eof   = (r_ridx == c_last_idx);
`endif
         end
         ST_CRC: begin
            out_if.out_valid = 1'b1;
            out_if.out_eof   = 1'b1;
`ifdef FRAME_CRC_EN
            out_if.out_data  = w_crc;
`endif
         end
         default: ;
      endcase
   end

   assign overflow  = r_overflow;
   assign ovf_count = r_ovf_count;

endmodule

`default_nettype wire
